// File: rtl/dmem_stall_responder_if.sv
// M-stage data-memory bus between the pipeline (master) and a memory
// responder (slave): request fields in, load data and handshake status out.
interface dmem_stall_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        misaligned;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  rdata, stall, done, misaligned
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output rdata, stall, done, misaligned
    );
endinterface

// File: rtl/dmem_stall_responder.sv
// Multi-cycle data-memory responder. Each access is accepted in IDLE,
// waits out LATENCY stall cycles, and completes with a one-cycle done pulse.
// The memory write / read happens on the edge that enters DONE, so load
// data is already on rdata while done is high.
module dmem_stall_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_stall_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            wr_reg;
    logic [AW+1:0]   addr_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     rdata_reg;
    logic            done_reg;
    logic            mis_reg;

    logic            latch_en;
    logic            acc_fire;
    logic            acc_write;
    logic [AW+1:0]   acc_addr;
    logic [31:0]     acc_wdata;
    logic [AW-1:0]   acc_idx;
    logic            acc_mis;
    logic            mem_we;
    logic            unused_addr_bits;

    // Not reset: contents survive reset by design.
    logic [31:0]     mem [DEPTH_WORDS];

    // Address bits above the array size wrap and are deliberately dropped.
    assign unused_addr_bits = &{1'b0, bus.req_addr[31:AW+2]};

    // Next-state, countdown and access-fire decode.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        acc_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    latch_en = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        acc_fire   = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = DONE;
                    acc_fire   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DONE: begin
                // The stalled instruction is still at M here; its request is not new.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With LATENCY==1 the access fires straight out of IDLE, so it must use
    // the live request; otherwise the latched copy is authoritative.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr[AW+1:0];
            acc_wdata = bus.req_wdata;
        end else begin
            acc_write = wr_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];
    assign acc_mis = (acc_addr[1:0] != 2'b00);
    // Gating with reset keeps a store from landing while reset is held.
    assign mem_we  = acc_fire & acc_write & ~acc_mis & reset;

    // Control state, latched request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            done_reg  <= 1'b0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_en) begin
                wr_reg    <= bus.req_write;
                addr_reg  <= bus.req_addr[AW+1:0];
                wdata_reg <= bus.req_wdata;
            end
            done_reg <= acc_fire;
            mis_reg  <= acc_fire & acc_mis;
            // Stores leave rdata alone; loads and misaligned accesses update it.
            if (acc_fire && (acc_mis || !acc_write)) begin
                rdata_reg <= acc_mis ? 32'h0 : mem[acc_idx];
            end
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.stall      = reset & (((state_reg == IDLE) & bus.req_valid) | (state_reg == BUSY));
    assign bus.rdata      = rdata_reg;
    assign bus.done       = done_reg;
    assign bus.misaligned = mis_reg;

endmodule

// File: tb/tb_dmem_stall_responder.sv
// Directed bench for dmem_stall_responder: a LATENCY=3 instance carries the
// main sequence, a LATENCY=1 instance covers the single-wait-state case.
module tb_dmem_stall_responder;

    localparam int LAT3 = 3;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    dmem_stall_responder_if bus3 ();
    dmem_stall_responder_if bus1 ();

    dmem_stall_responder #(.DEPTH_WORDS(64), .LATENCY(LAT3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    dmem_stall_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete access on the LATENCY=3 instance, followed by one idle cycle.
    task automatic run3(input bit sync, input string tag, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis,
                        input bit chg_inputs);
        if (sync) cyc();
        bus3.req_valid = 1'b1;
        bus3.req_write = wr;
        bus3.req_addr  = addr;
        bus3.req_wdata = wd;
        #1;
        chk({tag, " stall c0"}, 32'(bus3.stall), 32'd1);
        chk({tag, " done c0"},  32'(bus3.done),  32'd0);
        for (int i = 1; i < LAT3; i++) begin
            cyc();
            if (chg_inputs) begin
                bus3.req_wdata = 32'h0;
                bus3.req_addr  = 32'h0000_0008;
            end
            #1;
            chk($sformatf("%s stall c%0d", tag, i), 32'(bus3.stall), 32'd1);
            chk($sformatf("%s done c%0d", tag, i),  32'(bus3.done),  32'd0);
        end
        cyc();
        #1;
        chk({tag, " stall done"}, 32'(bus3.stall),      32'd0);
        chk({tag, " done"},       32'(bus3.done),       32'd1);
        chk({tag, " misaligned"}, 32'(bus3.misaligned), 32'(exp_mis));
        chk({tag, " rdata"},      bus3.rdata,           exp_rd);
        cyc();
        bus3.req_valid = 1'b0;
        #1;
        chk({tag, " stall idle"}, 32'(bus3.stall),      32'd0);
        chk({tag, " done idle"},  32'(bus3.done),       32'd0);
        chk({tag, " mis idle"},   32'(bus3.misaligned), 32'd0);
        $display("txn %s: wr=%0b addr=%h wdata=%h rdata=%h", tag, wr, addr, wd, bus3.rdata);
    endtask

    initial begin
        reset          = 1'b0;
        bus1.req_valid = 1'b0;
        bus1.req_write = 1'b0;
        bus1.req_addr  = 32'h0;
        bus1.req_wdata = 32'h0;
        // Request present while reset is held: reset must win.
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b1;
        bus3.req_addr  = 32'h0000_0014;
        bus3.req_wdata = 32'hDEAD_BEEF;
        cyc();
        cyc();
        #1;
        chk("reset stall",  32'(bus3.stall),      32'd0);
        chk("reset done",   32'(bus3.done),       32'd0);
        chk("reset mis",    32'(bus3.misaligned), 32'd0);
        chk("reset rdata",  bus3.rdata,           32'h0);
        chk("reset1 rdata", bus1.rdata,           32'h0);
        reset = 1'b1;

        // Release mid-cycle: stall must rise in this same cycle.
        run3(1'b0, "st14",  1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0);
        run3(1'b1, "ld14",  1'b0, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
        run3(1'b1, "mis16", 1'b1, 32'h0000_0016, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
        run3(1'b1, "ld14b", 0,    32'h0000_0014, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
        run3(1'b1, "st100", 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run3(1'b1, "ld0",   1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0, 1'b0);

        // LATENCY=1: store then load word 0.
        cyc();
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        bus1.req_addr  = 32'h0;
        bus1.req_wdata = 32'h1234_5678;
        #1;
        chk("l1 st stall", 32'(bus1.stall), 32'd1);
        cyc();
        #1;
        chk("l1 st done",  32'(bus1.done),  32'd1);
        chk("l1 st stall done", 32'(bus1.stall), 32'd0);
        chk("l1 st rdata", bus1.rdata,      32'h0);
        cyc();
        bus1.req_valid = 1'b0;
        #1;
        chk("l1 idle stall", 32'(bus1.stall), 32'd0);
        chk("l1 idle done",  32'(bus1.done),  32'd0);
        $display("txn l1st: wr=1 addr=00000000 wdata=12345678 rdata=%h", bus1.rdata);
        cyc();
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b0;
        #1;
        chk("l1 ld stall", 32'(bus1.stall), 32'd1);
        cyc();
        #1;
        chk("l1 ld done",  32'(bus1.done),       32'd1);
        chk("l1 ld stall done", 32'(bus1.stall), 32'd0);
        chk("l1 ld mis",   32'(bus1.misaligned), 32'd0);
        chk("l1 ld rdata", bus1.rdata,           32'h1234_5678);
        cyc();
        bus1.req_valid = 1'b0;
        $display("txn l1ld: wr=0 addr=00000000 rdata=%h", bus1.rdata);

        // Reset in the second BUSY cycle of a store must not touch memory.
        run3(1'b1, "st20", 1'b1, 32'h0000_0020, 32'h0000_0055, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cyc();
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b1;
        bus3.req_addr  = 32'h0000_0020;
        bus3.req_wdata = 32'h0000_0001;
        #1;
        chk("rst st stall c0", 32'(bus3.stall), 32'd1);
        cyc();
        #1;
        chk("rst st stall c1", 32'(bus3.stall), 32'd1);
        cyc();
        #1;
        chk("rst st stall c2", 32'(bus3.stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst stall drop", 32'(bus3.stall), 32'd0);
        chk("rst done drop",  32'(bus3.done),  32'd0);
        cyc();
        #1;
        chk("rst held done",  32'(bus3.done),  32'd0);
        chk("rst held stall", 32'(bus3.stall), 32'd0);
        chk("rst held rdata", bus3.rdata,      32'h0);
        bus3.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst release stall", 32'(bus3.stall), 32'd0);
        $display("txn rst_mid_store: stall=%0b done=%0b", bus3.stall, bus3.done);
        run3(1'b1, "ld20", 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0055, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
